// File: rtl/banked_reg_file.sv
// banked_reg_file: general registers plus PC, a kernel/user banked SP and a
// six-bit status word {N,Z,C,V,imask,mode} with interrupt save/restore.
// Reads are combinational from registered state; all updates on the rising edge.
module banked_reg_file #(
  parameter int                   WORD_SIZE    = 32,
  parameter int                   NUM_REGS     = 16,
  parameter int                   NUM_RD_PORTS = 2,
  parameter logic [WORD_SIZE-1:0] RESET_PC     = '0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_RD_PORTS-1:0][$clog2(NUM_REGS)-1:0] rd_sel,
  output logic [NUM_RD_PORTS-1:0][WORD_SIZE-1:0]        rd_data,
  input  logic                                         wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]                  wr_sel,
  input  logic [WORD_SIZE-1:0]                         wr_data,
  input  logic                                         pc_inc,
  input  logic                                         alu_status_wr_en,
  input  logic [3:0]                                   alu_status_in,
  input  logic                                         status_wr_en,
  input  logic [5:0]                                   status_in,
  input  logic                                         int_take,
  input  logic                                         int_ret,
  output logic [5:0]                                   status,
  output logic [WORD_SIZE-1:0]                         pc,
  output logic [WORD_SIZE-1:0]                         sp
);

  localparam int              IDX_W  = $clog2(NUM_REGS);
  localparam int              NUM_GP = NUM_REGS - 2;
  localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] SP_IDX = IDX_W'(NUM_REGS - 2);
  localparam logic [IDX_W:0]   NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

  // Indices 0..NUM_REGS-3 are plain registers (FP included); SP and PC live apart.
  logic [WORD_SIZE-1:0] regs_q [NUM_GP];
  logic [WORD_SIZE-1:0] regs_d [NUM_GP];
  logic [WORD_SIZE-1:0] sp_kernel_q, sp_kernel_d;
  logic [WORD_SIZE-1:0] sp_user_q, sp_user_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [5:0]           status_q, status_d;
  logic [5:0]           saved_status_q, saved_status_d;

  logic user_mode;
  logic wr_valid;
  logic wr_pc;

  assign user_mode = status_q[0];
  assign wr_valid  = wr_en && ({1'b0, wr_sel} < NUM_REGS_W);
  assign wr_pc     = wr_valid && (wr_sel == PC_IDX);

  // Next-state for registers, PC, and status; the SP bank uses the pre-edge mode.
  always_comb begin
    regs_d         = regs_q;
    sp_kernel_d    = sp_kernel_q;
    sp_user_d      = sp_user_q;
    pc_d           = pc_q;
    status_d       = status_q;
    saved_status_d = saved_status_q;

    if (wr_pc) begin
      pc_d = wr_data;
    end else if (pc_inc) begin
      pc_d = pc_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    end

    if (wr_valid && (wr_sel == SP_IDX)) begin
      if (user_mode) begin
        sp_user_d = wr_data;
      end else begin
        sp_kernel_d = wr_data;
      end
    end

    for (int i = 0; i < NUM_GP; i++) begin
      if (wr_valid && (wr_sel == IDX_W'(i))) begin
        regs_d[i] = wr_data;
      end
    end

    if (int_take) begin
      saved_status_d = status_q;
      status_d       = {status_q[5:2], 1'b1, 1'b0};
    end else if (int_ret) begin
      status_d = saved_status_q;
    end else if (status_wr_en) begin
      status_d = status_in;
    end else if (alu_status_wr_en) begin
      status_d = {alu_status_in, status_q[1:0]};
    end
  end

  // State registers; reset overrides every concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GP; i++) begin
        regs_q[i] <= '0;
      end
      sp_kernel_q    <= '0;
      sp_user_q      <= '0;
      pc_q           <= RESET_PC;
      status_q       <= 6'b000010;
      saved_status_q <= '0;
    end else begin
      regs_q         <= regs_d;
      sp_kernel_q    <= sp_kernel_d;
      sp_user_q      <= sp_user_d;
      pc_q           <= pc_d;
      status_q       <= status_d;
      saved_status_q <= saved_status_d;
    end
  end

  // Combinational read ports; indices with no register read as zero.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data[p] = '0;
      if (rd_sel[p] == PC_IDX) begin
        rd_data[p] = pc_q;
      end else if (rd_sel[p] == SP_IDX) begin
        rd_data[p] = user_mode ? sp_user_q : sp_kernel_q;
      end else begin
        for (int i = 0; i < NUM_GP; i++) begin
          if (rd_sel[p] == IDX_W'(i)) begin
            rd_data[p] = regs_q[i];
          end
        end
      end
    end
  end

  assign status = status_q;
  assign pc     = pc_q;
  assign sp     = user_mode ? sp_user_q : sp_kernel_q;

endmodule

// File: doc/banked_reg_file.md
BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data width of every register.
REQ-002 SHALL have parameter NUM_REGS, default 16, architectural register count (>= 4); index NUM_REGS-1 = PC, NUM_REGS-2 = SP, NUM_REGS-3 = FP.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, count of independent read ports (>= 1).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rd_sel  in  NUM_RD_PORTS x $clog2(NUM_REGS)  read register index per port.
REQ-009 rd_data  out  NUM_RD_PORTS x WORD_SIZE  read data per port.
REQ-010 wr_en / wr_sel / wr_data  in  1 / $clog2(NUM_REGS) / WORD_SIZE  general write port.
REQ-011 pc_inc  in  1  increment PC by 1.
REQ-012 alu_status_wr_en / alu_status_in  in  1 / 4  flag update {negative, zero, carry, overflow}.
REQ-013 status_wr_en / status_in  in  1 / 6  full status write {flags, imask, mode}.
REQ-014 int_take  in  1  interrupt entry; int_ret  in  1  interrupt return.
REQ-015 status  out  6  current status {N,Z,C,V,imask,mode}; mode 0 = kernel, 1 = user.
REQ-016 pc  out  WORD_SIZE  current PC; sp  out  WORD_SIZE  SP of active bank.

Function
REQ-017 SHALL hold two SP registers (kernel bank, user bank); index NUM_REGS-2 accesses the bank selected by current status.mode for reads and writes.
REQ-018 Reads SHALL be combinational from registered state; no write-to-read forwarding (write visible the cycle after the edge).
REQ-019 wr_en SHALL update the selected register on the rising edge; wr_sel >= NUM_REGS SHALL be ignored.
REQ-020 pc_inc SHALL set PC = PC + 1 modulo 2^WORD_SIZE (wrap all-ones -> 0).
REQ-021 wr_en to PC and pc_inc in same cycle: write wins, no increment.
REQ-022 alu_status_wr_en SHALL replace only the four flag bits.
REQ-023 status_wr_en SHALL replace all six status bits; with alu_status_wr_en same cycle: status_wr_en wins.
REQ-024 int_take SHALL copy status into saved_status, set mode = kernel, imask = 1, flags unchanged, ignoring status_wr_en/alu_status_wr_en that cycle.
REQ-025 int_ret SHALL restore status from saved_status; ignored when int_take also asserted; overrides status_wr_en/alu_status_wr_en.
REQ-026 SP write coincident with a mode change SHALL target the bank of the pre-edge mode.
REQ-027 Status update priority: rst > int_take > int_ret > status_wr_en > alu_status_wr_en.

Reset
REQ-028 rst SHALL clear all general registers, both SP banks and saved_status to 0, set PC = RESET_PC, status = {0000, imask=1, kernel}.
REQ-029 rst SHALL override all concurrent writes, increments and interrupt events, including mid-sequence.

Verification
REQ-030 Reset: rst high 1 cycle with wr_en=1 -> all rd_data 0, pc=RESET_PC, status=6'b000010.
REQ-031 Write/read: write R3=0xDEADBEEF, read on ports 0 and 1 same cycle -> old value; next cycle both = 0xDEADBEEF.
REQ-032 PC: PC=0xFFFFFFFF, pc_inc -> 0; pc_inc + wr_en(PC,0x100) -> PC=0x100.
REQ-033 Banking: kernel SP=0x1000, status_wr_en mode=user, user SP=0x2000 -> sp=0x2000; back to kernel -> sp=0x1000.
REQ-034 Interrupt: status=6'b101001 (user), int_take -> status=6'b101010, sp=kernel SP; int_ret -> status=6'b101001.
REQ-035 Priority: int_take + status_wr_en + alu_status_wr_en same cycle -> only interrupt entry effect observed.
